// File: rtl/port_drain.sv
// Upstream burst drain: solicits bursts from an upstream port when there is room,
// buffers every word it sees in a fall-through FIFO, and presents them downstream.
module port_drain #(
    parameter int WORD_WIDTH     = 128,
    parameter int UP_DEPTH       = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int LOG_FIFO_DEPTH = 4,
    parameter int REQ_TIMEOUT    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      up_have_data,
    input  logic                      up_is_writing,
    input  logic [WORD_WIDTH-1:0]     up_data,
    output logic                      up_read_enable,
    output logic [WORD_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LOG_FIFO_DEPTH:0]   word_count,
    output logic                      busy,
    output logic                      overflow
);

    localparam int TMO_W = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]          TMO_LAST   = TMO_W'(REQ_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]          TMO_ONE    = TMO_W'(1);
    localparam logic [LOG_FIFO_DEPTH:0]   DEPTH_C    = (LOG_FIFO_DEPTH + 1)'(FIFO_DEPTH);
    localparam logic [LOG_FIFO_DEPTH:0]   UP_DEPTH_C = (LOG_FIFO_DEPTH + 1)'(UP_DEPTH);
    localparam logic [LOG_FIFO_DEPTH:0]   CNT_ONE    = (LOG_FIFO_DEPTH + 1)'(1);
    localparam logic [LOG_FIFO_DEPTH-1:0] PTR_ONE    = LOG_FIFO_DEPTH'(1);

    typedef enum logic [1:0] {IDLE, REQ, RECV} state_t;

    state_t                    state_q, state_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic                      arm_q;
    logic                      up_read_enable_q;
    logic                      overflow_q, overflow_d;
    logic [LOG_FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_FIFO_DEPTH:0]   count_q, count_d;
    logic [WORD_WIDTH-1:0]     mem [FIFO_DEPTH];

    logic full, do_pop, do_push, room;

    // A pop on a full FIFO frees the slot the same cycle, so the push still lands.
    always_comb begin
        full     = (count_q == DEPTH_C);
        do_pop   = (count_q != '0) && out_ready;
        do_push  = up_is_writing && (!full || do_pop);
        room     = ((DEPTH_C - count_q) >= UP_DEPTH_C);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        overflow_d = overflow_q || (up_is_writing && !do_push);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (arm_q && up_have_data && room) begin
                    state_d = REQ;
                    tmo_d   = '0;
                end
            end
            REQ: begin
                if (up_is_writing) begin
                    state_d = RECV;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            RECV: begin
                if (!up_is_writing) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // arm_q holds the FSM off for the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            tmo_q            <= '0;
            arm_q            <= 1'b0;
            up_read_enable_q <= 1'b0;
            overflow_q       <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
        end else begin
            state_q          <= state_d;
            tmo_q            <= tmo_d;
            arm_q            <= 1'b1;
            up_read_enable_q <= (state_d == REQ);
            overflow_q       <= overflow_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= up_data;
        end
    end

    assign out_data       = mem[rd_ptr_q];
    assign out_valid      = (count_q != '0);
    assign word_count     = count_q;
    assign busy           = (state_q != IDLE);
    assign up_read_enable = up_read_enable_q;
    assign overflow       = overflow_q;

endmodule
